// File: rtl/rr_stream_arbiter.sv
// Round-robin N:1 stream arbiter with a two-entry registered output buffer.
// Entry B always holds the older beat when both entries are full.
module rr_stream_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 32,
    localparam int IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          flush_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [DATA_WIDTH-1:0]         data_o,
    output logic [IDX_W-1:0]              idx_o
);

    logic [IDX_W-1:0]      rr_q;
    logic                  a_full;
    logic [IDX_W-1:0]      a_idx;
    logic [DATA_WIDTH-1:0] a_data;
    logic                  b_full;
    logic [IDX_W-1:0]      b_idx;
    logic [DATA_WIDTH-1:0] b_data;

    logic                  grant_vld;
    logic [IDX_W-1:0]      grant_idx;
    logic [IDX_W-1:0]      cand;
    logic [IDX_W-1:0]      rr_next;
    logic [DATA_WIDTH-1:0] grant_data;
    logic                  buf_ready;
    logic                  in_fire;
    logic                  out_fire;

    // Scan from the lowest priority upward so the highest-priority hit is written last.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (int'(rr_q) + i >= NUM_REQ) begin
                cand = IDX_W'(int'(rr_q) + i - NUM_REQ);
            end else begin
                cand = IDX_W'(int'(rr_q) + i);
            end
            if (req_valid_i[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign rr_next    = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    assign grant_data = req_data_i[int'(grant_idx) * DATA_WIDTH +: DATA_WIDTH];

    // buf_ready comes from registers only, so ready_i never reaches req_ready_o.
    assign buf_ready   = !(a_full && b_full);
    assign in_fire     = rst_n_i && grant_vld && buf_ready && !flush_i;
    assign req_ready_o = in_fire ? (NUM_REQ'(1) << grant_idx) : '0;

    assign valid_o  = a_full || b_full;
    assign data_o   = b_full ? b_data : a_data;
    assign idx_o    = b_full ? b_idx  : a_idx;
    assign out_fire = valid_o && ready_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rr_q   <= '0;
            a_full <= 1'b0;
            a_idx  <= '0;
            a_data <= '0;
            b_full <= 1'b0;
            b_idx  <= '0;
            b_data <= '0;
        end else begin
            if (in_fire) begin
                rr_q <= rr_next;
            end
            if (flush_i) begin
                a_full <= 1'b0;
                b_full <= 1'b0;
            end else begin
                // A stalled beat is parked in B only when A must take a new one.
                if (b_full && out_fire) begin
                    b_full <= 1'b0;
                end else if (!b_full && a_full && !out_fire && in_fire) begin
                    b_full <= 1'b1;
                    b_idx  <= a_idx;
                    b_data <= a_data;
                end
                if (in_fire) begin
                    a_full <= 1'b1;
                    a_idx  <= grant_idx;
                    a_data <= grant_data;
                end else if (a_full && !b_full && out_fire) begin
                    a_full <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Directed bench for rr_stream_arbiter: stimulus pushes expected beats into a queue,
// a negedge monitor pops and compares each output handshake.
module tb_rr_stream_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 32;
    localparam int IDX_W      = 2;

    logic                          clk_i = 1'b0;
    logic                          rst_n_i;
    logic                          flush_i;
    logic [NUM_REQ-1:0]            req_valid_i;
    logic [NUM_REQ-1:0]            req_ready_o;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
    logic                          valid_o;
    logic                          ready_i;
    logic [DATA_WIDTH-1:0]         data_o;
    logic [IDX_W-1:0]              idx_o;

    logic [DATA_WIDTH-1:0]         word [NUM_REQ];
    logic [IDX_W+DATA_WIDTH-1:0]   exp_q [$];
    int                            checks = 0;
    int                            errors = 0;

    always #5 clk_i = ~clk_i;

    assign req_data_i = {word[3], word[2], word[1], word[0]};

    rr_stream_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .flush_i     (flush_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_data_i  (req_data_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .data_o      (data_o),
        .idx_o       (idx_o)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // One cycle: drive at posedge+1, check at negedge, record the expected transfer.
    task automatic applyStimulus(input string name, input logic [3:0] v, input logic rdy, input logic fl,
                                 input logic exp_valid, input logic [3:0] exp_mask);
        req_valid_i = v;
        ready_i     = rdy;
        flush_i     = fl;
        @(negedge clk_i);
        checkOutput({name, " valid_o"}, 64'(valid_o), 64'(exp_valid));
        checkOutput({name, " req_ready_o"}, 64'(req_ready_o), 64'(exp_mask));
        for (int k = 0; k < NUM_REQ; k++) begin
            if (exp_mask[k]) begin
                exp_q.push_back({IDX_W'(k), word[k]});
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    always @(negedge clk_i) begin
        if (rst_n_i && valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected beat: got idx %0d data %0h expected none", idx_o, data_o);
            end else begin
                checkOutput("beat", 64'({idx_o, data_o}), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int k = 0; k < NUM_REQ; k++) begin
            word[k] = 32'h1111_1111 * (k + 1);
        end
        rst_n_i     = 1'b0;
        flush_i     = 1'b0;
        ready_i     = 1'b1;
        req_valid_i = 4'b1111;
        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("reset valid_o", 64'(valid_o), 64'(0));
        checkOutput("reset req_ready_o", 64'(req_ready_o), 64'(0));
        checkOutput("reset data_o", 64'(data_o), 64'(0));
        checkOutput("reset idx_o", 64'(idx_o), 64'(0));
        req_valid_i = 4'b0000;
        rst_n_i     = 1'b1;

        // Fairness: 0,1,2,3,0,1,2,3 one per cycle
        applyStimulus("fair0", 4'b1111, 1'b1, 1'b0, 1'b0, 4'b0001);
        for (int c = 1; c < 8; c++) begin
            applyStimulus("fair", 4'b1111, 1'b1, 1'b0, 1'b1, 4'(1 << (c % 4)));
        end
        applyStimulus("fair drain", 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0000);
        applyStimulus("fair empty", 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000);

        // Skipping: grant 1 first to put rr at 2, then only 1 and 3 valid
        applyStimulus("skip setup", 4'b0010, 1'b1, 1'b0, 1'b0, 4'b0010);
        applyStimulus("skip g3a", 4'b1010, 1'b1, 1'b0, 1'b1, 4'b1000);
        applyStimulus("skip g1a", 4'b1010, 1'b1, 1'b0, 1'b1, 4'b0010);
        applyStimulus("skip g3b", 4'b1010, 1'b1, 1'b0, 1'b1, 4'b1000);
        applyStimulus("skip g1b", 4'b1010, 1'b1, 1'b0, 1'b1, 4'b0010);
        applyStimulus("skip drain", 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0000);
        applyStimulus("skip empty", 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000);

        // Backpressure: rr=2, two transfers then stall with beat 2 held on the output
        applyStimulus("bp t1", 4'b1111, 1'b0, 1'b0, 1'b0, 4'b0100);
        applyStimulus("bp t2", 4'b1111, 1'b0, 1'b0, 1'b1, 4'b1000);
        checkOutput("bp hold idx", 64'(idx_o), 64'(2));
        checkOutput("bp hold data", 64'(data_o), 64'(word[2]));
        for (int c = 0; c < 3; c++) begin
            applyStimulus("bp stall", 4'b1111, 1'b0, 1'b0, 1'b1, 4'b0000);
            checkOutput("bp hold idx", 64'(idx_o), 64'(2));
            checkOutput("bp hold data", 64'(data_o), 64'(word[2]));
        end
        applyStimulus("bp release", 4'b1111, 1'b1, 1'b0, 1'b1, 4'b0000);
        applyStimulus("bp regrant0", 4'b0001, 1'b1, 1'b0, 1'b1, 4'b0001);
        applyStimulus("bp drain", 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0000);
        applyStimulus("bp empty", 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000);

        // Flush: rr=1, buffer two beats, flush, then rr must still be 3
        applyStimulus("fl fill1", 4'b1111, 1'b0, 1'b0, 1'b0, 4'b0010);
        applyStimulus("fl fill2", 4'b1111, 1'b0, 1'b0, 1'b1, 4'b0100);
        applyStimulus("fl flush", 4'b1111, 1'b0, 1'b1, 1'b1, 4'b0000);
        exp_q.delete();
        applyStimulus("fl after", 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
        applyStimulus("fl rr kept", 4'b1111, 1'b1, 1'b0, 1'b0, 4'b1000);
        applyStimulus("fl drain", 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0000);
        applyStimulus("fl empty", 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000);

        // Latency: single beat visible one cycle after its transfer
        word[2] = 32'hA5A5_0001;
        applyStimulus("lat xfer", 4'b0100, 1'b1, 1'b0, 1'b0, 4'b0100);
        checkOutput("lat valid_o", 64'(valid_o), 64'(1));
        checkOutput("lat idx_o", 64'(idx_o), 64'(2));
        checkOutput("lat data_o", 64'(data_o), 64'(32'hA5A5_0001));
        applyStimulus("lat pop", 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0000);
        applyStimulus("lat empty", 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000);

        // Reset mid-stream: rr=3, two beats buffered, async reset clears them
        applyStimulus("rst fill1", 4'b1111, 1'b0, 1'b0, 1'b0, 4'b1000);
        applyStimulus("rst fill2", 4'b1111, 1'b0, 1'b0, 1'b1, 4'b0001);
        #2;
        rst_n_i = 1'b0;
        #1;
        checkOutput("rst async valid_o", 64'(valid_o), 64'(0));
        checkOutput("rst async req_ready_o", 64'(req_ready_o), 64'(0));
        checkOutput("rst async data_o", 64'(data_o), 64'(0));
        checkOutput("rst async idx_o", 64'(idx_o), 64'(0));
        exp_q.delete();
        req_valid_i = 4'b0000;
        repeat (2) @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        applyStimulus("rst first grant", 4'b1111, 1'b1, 1'b0, 1'b0, 4'b0001);
        applyStimulus("rst drain", 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0000);
        applyStimulus("rst empty", 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000);

        checkOutput("leftover expected beats", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_stream_arbiter.md
RR_STREAM_ARBITER -- requirements
Module: rr_stream_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (legal range 2..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, payload width.
REQ-003 SHALL define local IDX_W = $clog2(NUM_REQ).
REQ-004 SHALL have port clk_i  input  1  clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n_i  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port flush_i  input  1  synchronous discard of all buffered beats.
REQ-007 SHALL have port req_valid_i  input  NUM_REQ  per-requester valid.
REQ-008 SHALL have port req_ready_o  output  NUM_REQ  per-requester ready.
REQ-009 SHALL have port req_data_i  input  NUM_REQ*DATA_WIDTH  flattened payloads; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-010 SHALL have port valid_o  output  1  output beat valid.
REQ-011 SHALL have port ready_i  input  1  downstream ready.
REQ-012 SHALL have port data_o  output  DATA_WIDTH  output payload.
REQ-013 SHALL have port idx_o  output  IDX_W  index of the requester that sourced data_o.

Function
REQ-014 SHALL hold a round-robin pointer rr_q (IDX_W bits) giving the highest-priority requester.
REQ-015 SHALL grant, combinationally each cycle, the first asserted req_valid_i at index rr_q, rr_q+1, ... wrapping modulo NUM_REQ.
REQ-016 SHALL assert at most one req_ready_o bit: the granted bit, and only when buf_ready is 1 and flush_i is 0.
REQ-017 SHALL define an input transfer as req_valid_i[g] && req_ready_o[g]; on a transfer rr_q becomes (g+1) mod NUM_REQ, otherwise rr_q holds.
REQ-018 SHALL buffer {g, payload} of each transfer in a two-entry buffer (entries A and B); buf_ready = not (A full and B full).
REQ-019 SHALL write a new beat into A; when A is full, B is empty and ready_i is 0, A SHALL move to B in the same edge A is refilled.
REQ-020 SHALL present B on data_o/idx_o when B is full, else A; valid_o = A full or B full.
REQ-021 SHALL deliver a beat on valid_o exactly 1 cycle after its input transfer when the buffer was empty (no combinational path from req_* to valid_o/data_o/idx_o).
REQ-022 SHALL sustain one transfer per cycle while ready_i stays 1.
REQ-023 SHALL keep data_o and idx_o stable while valid_o=1 and ready_i=0.
REQ-024 SHALL output beats in input-transfer order.
REQ-025 SHALL have no combinational path from ready_i to any req_ready_o bit.
REQ-026 SHALL, on flush_i=1, clear both entries at the next edge, deassert all req_ready_o in that cycle, and leave rr_q unchanged.
REQ-027 SHALL let a requester drop req_valid_i without a transfer; arbitration re-evaluates the next cycle with no state change.
REQ-028 SHALL, when a grant is blocked by full buffer, grant the same requester once space frees if its valid is still high and no higher-priority request arrived.

Reset
REQ-029 SHALL, while rst_n_i=0, drive valid_o=0, req_ready_o=0, data_o=0, idx_o=0, rr_q=0, A and B empty.
REQ-030 SHALL, on rst_n_i assertion mid-transfer, discard buffered beats immediately with no output handshake.
REQ-031 SHALL, in the first cycle after reset release with all req_valid_i=1, grant requester 0.

Verification
REQ-032 SHALL test fairness: NUM_REQ=4, all valid, ready_i=1 -> idx_o sequence 0,1,2,3,0,... one beat per cycle.
REQ-033 SHALL test skipping: only req 1 and req 3 valid, rr_q=2 -> grants 3,1,3,1.
REQ-034 SHALL test backpressure: ready_i=0 for 5 cycles with all valid -> exactly 2 transfers, then req_ready_o=0, data_o stable; ready_i=1 releases beats in order.
REQ-035 SHALL test flush: buffer holding 2 beats, flush_i=1 for one cycle -> valid_o=0 next cycle, req_ready_o=0 during flush, rr_q unchanged.
REQ-036 SHALL test latency: single req 2 with data 0xA5A5_0001 at cycle t -> valid_o=1, idx_o=2, data_o=0xA5A5_0001 at cycle t+1.
REQ-037 SHALL test reset mid-stream: rst_n_i low with 2 buffered beats -> valid_o=0 asynchronously; after release, all valid -> first grant is requester 0.
